// File: rtl/seven_segment_scan_reader_if.sv
// Bundle of the multiplexed 7-segment bus and the decoded-frame outputs.
//   seg          : segment lines a..g on seg[6..0], active-high lit
//   an           : one-hot digit enables, active-high
//   digits       : decoded frame, digit k at [4k+3:4k]
//   digit_blank  : digit k was all-segments-off in the frame
//   digit_bad    : digit k held a pattern outside the hex table
//   frame_valid  : one-cycle strobe when the frame outputs update
//   an_error     : one-cycle strobe when a settled an was not one-hot
// master drives the display side, slave is the reader.
interface seven_segment_scan_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_blank;
    logic [DIGITS-1:0]   digit_bad;
    logic                frame_valid;
    logic                an_error;

    modport master (
        output seg, an,
        input  digits, digit_blank, digit_bad, frame_valid, an_error
    );

    modport slave (
        input  seg, an,
        output digits, digit_blank, digit_bad, frame_valid, an_error
    );
endinterface

// File: rtl/seven_segment_scan_reader.sv
// Receive end of a multiplexed 7-segment display bus. Each {seg,an} value
// must hold for STABLE_CYCLES edges before it is captured; a one-hot an
// stores the decoded hex value into that digit's shadow slot, and once every
// digit has been seen the whole frame is presented with a one-cycle
// frame_valid. A settled an that is not one-hot raises a one-cycle an_error.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : seven_segment_scan_reader_if slave (seg/an in, frame out)
module seven_segment_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                         clk,
    input logic                         reset,
    seven_segment_scan_reader_if.slave  bus
);
    localparam int              CW  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   SAT = CW'(STABLE_CYCLES);

    // Returns {bad, blank, value[3:0]}.
    function automatic logic [5:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1111110: decode_seg = 6'h00;
            7'b0110000: decode_seg = 6'h01;
            7'b1101101: decode_seg = 6'h02;
            7'b1111001: decode_seg = 6'h03;
            7'b0110011: decode_seg = 6'h04;
            7'b1011011: decode_seg = 6'h05;
            7'b1011111: decode_seg = 6'h06;
            7'b1110000: decode_seg = 6'h07;
            7'b1111111: decode_seg = 6'h08;
            7'b1111011: decode_seg = 6'h09;
            7'b1110111: decode_seg = 6'h0A;
            7'b0011111: decode_seg = 6'h0B;
            7'b1001110: decode_seg = 6'h0C;
            7'b0111101: decode_seg = 6'h0D;
            7'b1001111: decode_seg = 6'h0E;
            7'b1000111: decode_seg = 6'h0F;
            7'b0000000: decode_seg = 6'b01_0000;
            default:    decode_seg = 6'b10_0000;
        endcase
    endfunction

    logic [7+DIGITS-1:0] sample;
    logic [7+DIGITS-1:0] last_sample;
    logic [CW-1:0]       stab_cnt;
    logic [CW-1:0]       cnt_next;
    logic                armed;
    logic                arm_next;
    logic                capture;
    logic                onehot;
    logic                frame_done;
    logic [5:0]          dec;
    logic [DIGITS-1:0]   seen;
    logic [DIGITS-1:0]   seen_next;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_blank;
    logic [DIGITS-1:0]   shadow_bad;
    logic [4*DIGITS-1:0] merged_val;
    logic [DIGITS-1:0]   merged_blank;
    logic [DIGITS-1:0]   merged_bad;

    always_comb begin
        sample = {bus.seg, bus.an};
        dec    = decode_seg(bus.seg);
        onehot = $onehot(bus.an);

        // Any change restarts the count and re-arms; a match counts up and
        // saturates, so a long hold never produces a second capture.
        if (sample != last_sample) begin
            cnt_next = CW'(1);
            arm_next = 1'b1;
        end else begin
            cnt_next = (stab_cnt == SAT) ? stab_cnt : stab_cnt + CW'(1);
            arm_next = armed;
        end
        capture = arm_next && (cnt_next == SAT);

        seen_next  = seen | bus.an;
        frame_done = capture && onehot && (seen_next == '1);

        // Shadows with the current capture folded in, so a completing frame
        // includes the digit captured on this very edge.
        merged_val   = shadow_val;
        merged_blank = shadow_blank;
        merged_bad   = shadow_bad;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.an[i]) begin
                merged_val[4*i +: 4] = dec[3:0];
                merged_blank[i]      = dec[4];
                merged_bad[i]        = dec[5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_sample     <= '0;
            stab_cnt        <= '0;
            armed           <= 1'b1;
            seen            <= '0;
            shadow_val      <= '0;
            shadow_blank    <= '0;
            shadow_bad      <= '0;
            bus.digits      <= '0;
            bus.digit_blank <= '0;
            bus.digit_bad   <= '0;
            bus.frame_valid <= 1'b0;
            bus.an_error    <= 1'b0;
        end else begin
            last_sample     <= sample;
            stab_cnt        <= cnt_next;
            armed           <= arm_next && !capture;
            bus.frame_valid <= frame_done;
            bus.an_error    <= capture && !onehot;
            if (capture && onehot) begin
                shadow_val   <= merged_val;
                shadow_blank <= merged_blank;
                shadow_bad   <= merged_bad;
                if (frame_done) begin
                    bus.digits      <= merged_val;
                    bus.digit_blank <= merged_blank;
                    bus.digit_bad   <= merged_bad;
                    seen            <= '0;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Bench for seven_segment_scan_reader (DIGITS=4, STABLE_CYCLES=4): directed
// sequences, a table of decode vectors, and random traffic compared every
// cycle against a behavioural model.
module tb_seven_segment_scan_reader;
    localparam int D = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seven_segment_scan_reader_if #(.DIGITS(D)) bus ();

    seven_segment_scan_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int ae_cnt   = 0;

    // Segment encoder: hex value -> lit segments a..g.
    logic [6:0] enc [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        logic [6:0] seg;
        logic [3:0] val;
        logic       blank;
        logic       bad;
    } vec_t;
    vec_t vecs [18];

    // Behavioural model state
    int          run;
    logic [10:0] m_last;
    logic [3:0]  m_seen;
    logic [3:0]  m_val [D];
    logic        m_blank [D];
    logic        m_bad [D];
    logic [15:0] e_digits;
    logic [3:0]  e_blank, e_bad;
    logic        e_fv, e_ae;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_decode(input logic [6:0] s, output logic [3:0] v,
                                output logic bl, output logic bd);
        v  = 4'h0;
        bl = (s == 7'b0);
        bd = !bl;
        for (int i = 0; i < 16; i++)
            if (enc[i] == s) begin
                v  = 4'(i);
                bd = 1'b0;
            end
    endtask

    task automatic model_edge();
        logic [10:0] cur;
        if (reset) begin
            run = 0; m_last = '0; m_seen = '0;
            for (int i = 0; i < D; i++) begin
                m_val[i] = '0; m_blank[i] = 1'b0; m_bad[i] = 1'b0;
            end
            e_digits = '0; e_blank = '0; e_bad = '0; e_fv = 1'b0; e_ae = 1'b0;
        end else begin
            cur = {bus.seg, bus.an};
            if (cur != m_last) run = 1;
            else run++;
            m_last = cur;
            e_fv = 1'b0;
            e_ae = 1'b0;
            // A value is captured exactly when its unbroken run reaches S.
            if (run == S) begin
                if ($countones(bus.an) == 1) begin
                    for (int k = 0; k < D; k++)
                        if (bus.an[k]) begin
                            model_decode(bus.seg, m_val[k], m_blank[k], m_bad[k]);
                            m_seen[k] = 1'b1;
                        end
                    if (m_seen == 4'hF) begin
                        for (int k = 0; k < D; k++) begin
                            e_digits[4*k +: 4] = m_val[k];
                            e_blank[k] = m_blank[k];
                            e_bad[k]   = m_bad[k];
                        end
                        e_fv   = 1'b1;
                        m_seen = '0;
                    end
                end else begin
                    e_ae = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            bus.seg = s;
            bus.an  = a;
            @(posedge clk);
            model_edge();
            #1;
            if (bus.frame_valid) fv_cnt++;
            if (bus.an_error) ae_cnt++;
            chk("cycle_outputs",
                {6'b0, bus.frame_valid, bus.an_error, bus.digit_bad, bus.digit_blank, bus.digits},
                {6'b0, e_fv, e_ae, e_bad, e_blank, e_digits});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(7'b0, 4'b0, 2);
        reset = 1'b0;
    endtask

    initial begin
        int fv0, ae0;
        logic [3:0] a;
        logic [6:0] s;

        vecs = '{
            '{7'b1111110, 4'h0, 1'b0, 1'b0}, '{7'b0110000, 4'h1, 1'b0, 1'b0},
            '{7'b1101101, 4'h2, 1'b0, 1'b0}, '{7'b1111001, 4'h3, 1'b0, 1'b0},
            '{7'b0110011, 4'h4, 1'b0, 1'b0}, '{7'b1011011, 4'h5, 1'b0, 1'b0},
            '{7'b1011111, 4'h6, 1'b0, 1'b0}, '{7'b1110000, 4'h7, 1'b0, 1'b0},
            '{7'b1111111, 4'h8, 1'b0, 1'b0}, '{7'b1111011, 4'h9, 1'b0, 1'b0},
            '{7'b1110111, 4'hA, 1'b0, 1'b0}, '{7'b0011111, 4'hB, 1'b0, 1'b0},
            '{7'b1001110, 4'hC, 1'b0, 1'b0}, '{7'b0111101, 4'hD, 1'b0, 1'b0},
            '{7'b1001111, 4'hE, 1'b0, 1'b0}, '{7'b1000111, 4'hF, 1'b0, 1'b0},
            '{7'b0000000, 4'h0, 1'b1, 1'b0}, '{7'b0000001, 4'h0, 1'b0, 1'b1}
        };

        bus.seg = '0;
        bus.an  = '0;
        do_reset();
        chk("reset_state",
            {6'b0, bus.frame_valid, bus.an_error, bus.digit_bad, bus.digit_blank, bus.digits}, 32'h0);

        // Basic scan
        step(7'b0110000, 4'b0001, 6);
        step(7'b1101101, 4'b0010, 6);
        step(7'b1111001, 4'b0100, 6);
        step(7'b0110011, 4'b1000, 6);
        chk("scan_fv_count", 32'(fv_cnt), 32'd1);
        chk("scan_digits", 32'(bus.digits), 32'h4321);
        chk("scan_flags", {24'b0, bus.digit_bad, bus.digit_blank}, 32'h0);

        // Loopback of every table pattern through digit 0
        foreach (vecs[i]) begin
            fv0 = fv_cnt;
            step(enc[5], 4'b0010, 5);
            step(enc[6], 4'b0100, 5);
            step(enc[7], 4'b1000, 5);
            step(vecs[i].seg, 4'b0001, 5);
            chk("loop_fv", 32'(fv_cnt), 32'(fv0 + 1));
            chk("loop_digit", {16'b0, bus.digits}, {16'h0, 12'h765, vecs[i].val});
            chk("loop_flags", {30'b0, bus.digit_blank[0], bus.digit_bad[0]},
                {30'b0, vecs[i].blank, vecs[i].bad});
        end

        // Stability threshold and single capture on long hold
        fv0 = fv_cnt; ae0 = ae_cnt;
        step(enc[1], 4'b0010, 5);
        step(enc[2], 4'b0100, 5);
        step(enc[3], 4'b1000, 5);
        step(enc[8], 4'b0001, 3);
        step(7'b0, 4'b0000, 2);
        chk("short_hold_no_frame", 32'(fv_cnt), 32'(fv0));
        step(enc[8], 4'b0001, 4);
        chk("hold4_frame", 32'(fv_cnt), 32'(fv0 + 1));
        chk("hold4_digits", 32'(bus.digits), 32'h3218);
        step(enc[1], 4'b0010, 5);
        step(enc[2], 4'b0100, 5);
        step(enc[3], 4'b1000, 5);
        step(enc[9], 4'b0001, 50);
        chk("hold50_single", 32'(fv_cnt), 32'(fv0 + 2));
        chk("hold_no_an_error", 32'(ae_cnt), 32'(ae0));

        // Non-one-hot enables
        fv0 = fv_cnt; ae0 = ae_cnt;
        step(enc[10], 4'b0010, 5);
        step(enc[11], 4'b0100, 5);
        step(enc[12], 4'b1000, 5);
        step(enc[2], 4'b0011, 5);
        chk("an_multi_error", 32'(ae_cnt), 32'(ae0 + 1));
        step(enc[2], 4'b0000, 5);
        chk("an_zero_error", 32'(ae_cnt), 32'(ae0 + 2));
        chk("an_error_no_frame", 32'(fv_cnt), 32'(fv0));
        step(enc[4], 4'b0001, 5);
        chk("after_error_frame", 32'(fv_cnt), 32'(fv0 + 1));
        chk("after_error_digits", 32'(bus.digits), 32'hCBA4);

        // Blank and bad slots
        step(enc[1], 4'b0001, 5);
        step(7'b0000001, 4'b0010, 5);
        step(7'b0000000, 4'b0100, 5);
        step(enc[3], 4'b1000, 5);
        chk("blank_bad_digits", 32'(bus.digits), 32'h3001);
        chk("blank_mask", 32'(bus.digit_blank), 32'h4);
        chk("bad_mask", 32'(bus.digit_bad), 32'h2);

        // Reset mid-frame
        fv0 = fv_cnt;
        step(enc[1], 4'b0001, 5);
        step(enc[2], 4'b0010, 5);
        step(enc[3], 4'b0100, 5);
        do_reset();
        chk("midreset_cleared", 32'(bus.digits), 32'h0);
        step(enc[13], 4'b1000, 6);
        step(enc[15], 4'b0001, 6);
        step(enc[14], 4'b0010, 6);
        chk("midreset_no_frame", 32'(fv_cnt), 32'(fv0));
        step(enc[12], 4'b0100, 6);
        chk("postreset_frame", 32'(fv_cnt), 32'(fv0 + 1));
        chk("postreset_digits", 32'(bus.digits), 32'hDCEF);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 4'b0000;
                1:       a = 4'($urandom);
                default: a = 4'b0001 << $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 3) == 0) s = 7'($urandom);
            else s = enc[$urandom_range(0, 15)];
            if ($urandom_range(0, 60) == 0) do_reset();
            step(s, a, int'($urandom_range(1, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
